// File: rtl/switch_config_loader.sv
// switch_config_loader
//
// Loads a 16-entry crosspoint map (one 4-bit input-port index per switch
// output) into a shadow store. The map is streamed in order, output 0 first.
// Once all 16 entries are in, the whole shadow map is copied into the active
// map on a single edge, so every select changes together.
//
// Ports
//   clk_i         sole clock, rising edge
//   rst_i         synchronous active-high reset
//   start_i       request to begin loading a new map (ignored while busy)
//   abort_i       cancel a load in progress (LOAD state only)
//   cfg_valid_i   cfg_data_i carries a map entry
//   cfg_data_i    input-port index for output load_idx_o
//   cfg_ready_o   loader accepts cfg_data_i this cycle
//   sel0_o..15_o  registered active crosspoint selects
//   busy_o        state is not IDLE
//   done_o        one-cycle pulse when a new map becomes active
//   aborted_o     one-cycle pulse when a load is cancelled
//   load_idx_o    index of the next entry to be written
module switch_config_loader #(
    parameter bit IDENTITY_RESET = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       cfg_valid_i,
    input  logic [3:0] cfg_data_i,
    output logic       cfg_ready_o,
    output logic [3:0] sel0_o,
    output logic [3:0] sel1_o,
    output logic [3:0] sel2_o,
    output logic [3:0] sel3_o,
    output logic [3:0] sel4_o,
    output logic [3:0] sel5_o,
    output logic [3:0] sel6_o,
    output logic [3:0] sel7_o,
    output logic [3:0] sel8_o,
    output logic [3:0] sel9_o,
    output logic [3:0] sel10_o,
    output logic [3:0] sel11_o,
    output logic [3:0] sel12_o,
    output logic [3:0] sel13_o,
    output logic [3:0] sel14_o,
    output logic [3:0] sel15_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       aborted_o,
    output logic [3:0] load_idx_o
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCommit
    } state_e;

    state_e     state_q;
    logic [3:0] load_idx_q;
    logic       ready_q;
    logic       busy_q;
    logic       done_q;
    logic       aborted_q;
    logic [3:0] shadow_q [16];
    logic [3:0] active_q [16];

    // All outputs are plain registers; ready/busy are tracked alongside the
    // state so no output decodes the state combinationally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            load_idx_q <= 4'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                shadow_q[k] <= IDENTITY_RESET ? 4'(k) : 4'd0;
                active_q[k] <= IDENTITY_RESET ? 4'(k) : 4'd0;
            end
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // abort has no meaning here, so start always wins
                    if (start_i) begin
                        state_q    <= StLoad;
                        load_idx_q <= 4'd0;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                StLoad: begin
                    // abort beats a coincident data beat; the beat is dropped
                    if (abort_i) begin
                        state_q    <= StIdle;
                        load_idx_q <= 4'd0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        aborted_q  <= 1'b1;
                    end else if (cfg_valid_i) begin
                        shadow_q[load_idx_q] <= cfg_data_i;
                        load_idx_q           <= load_idx_q + 4'd1;  // 15 wraps to 0
                        if (load_idx_q == 4'd15) begin
                            state_q <= StCommit;
                            ready_q <= 1'b0;
                        end
                    end
                end
                StCommit: begin
                    // Whole-map copy on one edge: all selects switch together.
                    active_q <= shadow_q;
                    state_q  <= StIdle;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
    assign load_idx_o  = load_idx_q;

    assign sel0_o  = active_q[0];
    assign sel1_o  = active_q[1];
    assign sel2_o  = active_q[2];
    assign sel3_o  = active_q[3];
    assign sel4_o  = active_q[4];
    assign sel5_o  = active_q[5];
    assign sel6_o  = active_q[6];
    assign sel7_o  = active_q[7];
    assign sel8_o  = active_q[8];
    assign sel9_o  = active_q[9];
    assign sel10_o = active_q[10];
    assign sel11_o = active_q[11];
    assign sel12_o = active_q[12];
    assign sel13_o = active_q[13];
    assign sel14_o = active_q[14];
    assign sel15_o = active_q[15];

endmodule
